// File: rtl/ldl_fifo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : LDL_fifo_pkg                                              |
// | Shared pointer and occupancy helpers for the dual-pointer FIFO.     |
// | The write-side and read-side stages both use these helpers.         |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package LDL_fifo_pkg;

   // Depth of the read-ahead buffer and the width of its entry count.
   localparam int unsigned c_pf_depth = 2;
   localparam int unsigned c_bcnt_w   = 2;

   // A FIFO with AW address bits uses pointers one bit wider; the extra
   // MSB is the wrap bit that separates full from empty.
   function automatic int unsigned ptr_w(input int unsigned aw);
      return aw + 1;
   endfunction

   // Words between two pointers, reduced modulo the RAM depth.
   // Callers zero-extend their pointers to 32 bits and cut the result
   // back to AW bits.
   function automatic logic [31:0] occ_cnt(input logic [31:0] w,
                                           input logic [31:0] r,
                                           input int unsigned aw);
      logic [31:0] mask;
      mask = (32'd1 << aw) - 32'd1;
      return (w - r) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ldl_fifo_prefetch2.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ldl_fifo_prefetch2                                        |
// | Two-entry head/tail buffer that sits behind a 1-cycle-latency RAM.  |
// | A pop and a load may happen together. The loaded word goes to the   |
// | head when the buffer is empty after the pop, else to the tail.      |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module ldl_fifo_prefetch2
   import LDL_fifo_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [DW-1:0]       i_din,
   input  logic                i_pop,
   output logic [c_bcnt_w-1:0] o_bcnt,
   output logic [DW-1:0]       o_head
);

   logic [c_bcnt_w-1:0] r_bcnt;
   logic [DW-1:0]       r_head;
   logic [DW-1:0]       r_tail;
   logic [c_bcnt_w-1:0] w_after_pop;

   // Entries left once this cycle's pop has been taken.
   assign w_after_pop = r_bcnt - c_bcnt_w'(i_pop);

   // Count update, tail-to-head shift on pop, and placement of the load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcnt <= '0;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         r_bcnt <= w_after_pop + c_bcnt_w'(i_load);
         if (i_pop && (r_bcnt == c_bcnt_w'(c_pf_depth))) begin
            r_head <= r_tail;
         end
         if (i_load) begin
            if (w_after_pop == '0) begin
               r_head <= i_din;
            end else begin
               r_tail <= i_din;
            end
         end
      end
   end

   assign o_bcnt = r_bcnt;
   assign o_head = r_head;

endmodule
`default_nettype wire

// File: rtl/ldl_fifo_rs_v1.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ldl_fifo_rs_v1                                            |
// | Read-side pointer/control stage of the dual-pointer FIFO. It drives |
// | a synchronous-read RAM and returns r_pt to the write side.          |
// | AHEAD=1 : first-word-fall-through through a 2-entry prefetch buffer.|
// | AHEAD=0 : plain FIFO, data arrives on md one cycle after mr.        |
// | Option  : `define LDL_FIFO_RS_UDF_EN to add the sticky udf output.  |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module ldl_fifo_rs_v1
   import LDL_fifo_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DW    = 8,
   parameter int AHEAD = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   re,
   output logic                   empty,
   output logic [DW-1:0]          dout,
   output logic [AW-1:0]          ra,
   output logic                   mr,
   input  logic [DW-1:0]          md,
   input  logic [ptr_w(AW)-1:0]   w_pt,
   output logic [ptr_w(AW)-1:0]   r_pt,
   output logic [AW-1:0]          rcnt
`ifdef LDL_FIFO_RS_UDF_EN
   ,
   output logic                   udf
`endif
);

   localparam int PW = ptr_w(AW);

   logic [PW-1:0] r_rpt;
   logic          w_mem_ne;
   logic          w_mr;
   logic          w_empty;
   logic [DW-1:0] w_dout;

   // The MSB wrap bit lets a plain inequality tell "data in RAM" apart
   // from "empty", even when the RAM is completely full.
   assign w_mem_ne = (w_pt != r_rpt);

   // Each RAM fetch moves the read pointer on by one word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rpt <= '0;
      end else if (w_mr) begin
         r_rpt <= r_rpt + PW'(1);
      end
   end

   generate
      if (AHEAD != 0) begin : g_ahead
         logic                r_pend;
         logic                w_pop;
         logic [c_bcnt_w-1:0] w_bcnt;
         logic [2:0]          w_fill;

         assign w_empty = (w_bcnt == '0);
         assign w_pop   = re & ~w_empty;
         // Buffer occupancy next cycle, counting the word in flight.
         // A new fetch is allowed only while that stays below capacity.
         assign w_fill  = 3'(w_bcnt) + 3'(r_pend) - 3'(w_pop);
         assign w_mr    = w_mem_ne & (w_fill < 3'(c_pf_depth));

         // Marks that the RAM returns a word on md next cycle.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_pend <= 1'b0;
            end else begin
               r_pend <= w_mr;
            end
         end

         ldl_fifo_prefetch2 #(
            .DW (DW)
         ) u_prefetch (
            .clk    (clk),
            .rst    (rst),
            .i_load (r_pend),
            .i_din  (md),
            .i_pop  (w_pop),
            .o_bcnt (w_bcnt),
            .o_head (w_dout)
         );
      end else begin : g_std
         assign w_empty = ~w_mem_ne;
         assign w_mr    = re & ~w_empty;
         assign w_dout  = md;
      end
   endgenerate

`ifdef LDL_FIFO_RS_UDF_EN
   logic r_udf;

   // Records any read attempted while empty; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_udf <= 1'b0;
      end else if (re && w_empty) begin
         r_udf <= 1'b1;
      end
   end

   assign udf = r_udf;
`endif

   // The RAM port stays quiet while reset is held, even if the write side
   // already shows data. The pointer is held in reset at the same time.
   assign mr    = w_mr & rst;
   assign ra    = r_rpt[AW-1:0];
   assign r_pt  = r_rpt;
   assign rcnt  = AW'(occ_cnt(32'(w_pt), 32'(r_rpt), AW));
   assign empty = w_empty;
   assign dout  = w_dout;

endmodule
`default_nettype wire
